// File: rtl/brmask_alloc_if.sv
// Allocator-side bundle: dispatch request/grant, branch resolution, status.
// Carries o_killvec only when BRMASK_ALLOC_KILLVEC_EN is defined.
interface brmask_alloc_if #(
  parameter int WIDTH_BRM = 4
);
  localparam int DEPTH = 1 << WIDTH_BRM;

  logic                 i_alloc;
  logic                 o_gnt;
  logic                 o_ready;
  logic [WIDTH_BRM-1:0] o_tag;
  logic [WIDTH_BRM:0]   i_brmask;
  logic                 i_valid;
  logic                 o_flush;
  logic [WIDTH_BRM:0]   o_count;
  logic                 o_empty;
`ifdef BRMASK_ALLOC_KILLVEC_EN
  logic [DEPTH-1:0]     o_killvec;

  modport master (
    output i_alloc, i_brmask, i_valid,
    input  o_gnt, o_ready, o_tag, o_flush, o_count, o_empty, o_killvec
  );
  modport slave (
    input  i_alloc, i_brmask, i_valid,
    output o_gnt, o_ready, o_tag, o_flush, o_count, o_empty, o_killvec
  );
`else
  modport master (
    output i_alloc, i_brmask, i_valid,
    input  o_gnt, o_ready, o_tag, o_flush, o_count, o_empty
  );
  modport slave (
    input  i_alloc, i_brmask, i_valid,
    output o_gnt, o_ready, o_tag, o_flush, o_count, o_empty
  );
`endif
endinterface

// File: rtl/brmask_alloc.sv
// Circular branch-tag allocator with in-order retirement and kill rollback.
// Optional registered squash vector under BRMASK_ALLOC_KILLVEC_EN.
module brmask_slot (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_resolved
);
  // Clear wins: a retiring or squashed slot must not stay marked.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)   o_resolved <= 1'b0;
    else if (i_clr) o_resolved <= 1'b0;
    else if (i_set) o_resolved <= 1'b1;
endmodule

module brmask_alloc #(
  parameter int WIDTH_BRM = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  brmask_alloc_if.slave bus
);
  localparam int DEPTH = 1 << WIDTH_BRM;
  localparam logic [WIDTH_BRM-1:0] ONE_T   = WIDTH_BRM'(1);
  localparam logic [WIDTH_BRM:0]   ONE_P   = (WIDTH_BRM+1)'(1);
  localparam logic [WIDTH_BRM:0]   DEPTH_P = {1'b1, {WIDTH_BRM{1'b0}}};

  logic [WIDTH_BRM:0]                  head, tail, count;
  logic [WIDTH_BRM-1:0]                head_idx, res_tag, res_off;
  logic                                in_flight, res_acc, kill_acc, retire, gnt, ready;
  logic [DEPTH-1:0]                    resolved, set_vec, clr_vec, squash_vec;
  logic [DEPTH-1:0][WIDTH_BRM-1:0]     slot_off;
  logic                                flush_q;

  assign count    = tail - head;
  assign head_idx = head[WIDTH_BRM-1:0];
  assign ready    = (count < DEPTH_P);

  // Execute reports tag+1 so an all-zero mask means "no branch".
  assign res_tag   = bus.i_brmask[WIDTH_BRM-1:0] - ONE_T;
  assign res_off   = res_tag - head_idx;
  assign in_flight = ({1'b0, res_off} < count);
  assign res_acc   = bus.i_valid & in_flight;
  assign kill_acc  = res_acc & bus.i_brmask[WIDTH_BRM];
  assign retire    = (count != '0) & resolved[head_idx];
  assign gnt       = bus.i_alloc & ready & ~bus.i_brmask[WIDTH_BRM];

  always_comb begin
    slot_off   = '0;
    set_vec    = '0;
    clr_vec    = '0;
    squash_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i]   = WIDTH_BRM'(i) - head_idx;
      squash_vec[i] = kill_acc && (slot_off[i] > res_off) && ({1'b0, slot_off[i]} < count);
      set_vec[i]    = res_acc && (res_tag == WIDTH_BRM'(i));
      clr_vec[i]    = squash_vec[i] || (retire && (head_idx == WIDTH_BRM'(i)));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    brmask_slot u_slot (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_set      (set_vec[g]),
      .i_clr      (clr_vec[g]),
      .o_resolved (resolved[g])
    );
  end

  // Kill rebuilds tail from head+offset so the wrap bit stays consistent.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      head    <= '0;
      tail    <= '0;
      flush_q <= 1'b0;
    end else begin
      if (retire)        head <= head + ONE_P;
      if (kill_acc)      tail <= head + {1'b0, res_off} + ONE_P;
      else if (gnt)      tail <= tail + ONE_P;
      flush_q <= kill_acc;
    end

`ifdef BRMASK_ALLOC_KILLVEC_EN
  logic [DEPTH-1:0] killvec_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) killvec_q <= '0;
    else          killvec_q <= kill_acc ? squash_vec : '0;
  assign bus.o_killvec = killvec_q;
`endif

  assign bus.o_gnt   = gnt;
  assign bus.o_ready = ready;
  assign bus.o_tag   = tail[WIDTH_BRM-1:0];
  assign bus.o_flush = flush_q;
  assign bus.o_count = count;
  assign bus.o_empty = (count == '0);
endmodule

// File: doc/brmask_alloc.md
BRMASK_ALLOC -- requirements
Module: brmask_alloc

Interface
REQ-001 The block SHALL have parameter WIDTH_BRM, default 4, giving the branch tag width; it holds DEPTH = 2^WIDTH_BRM tags.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_alloc, input, 1 bit: dispatch requests a tag for a branch or jump.
REQ-005 The block SHALL have port o_gnt, output, 1 bit: combinational, equal to i_alloc & o_ready & ~i_brmask[WIDTH_BRM].
REQ-006 The block SHALL have port o_ready, output, 1 bit: combinational, high when count < DEPTH.
REQ-007 The block SHALL have port o_tag, output, WIDTH_BRM bits: the tag the next grant receives, equal to the tail pointer's low bits.
REQ-008 The block SHALL have port i_brmask, input, WIDTH_BRM+1 bits: {kill, resolved_tag+1}, from the branch execute stage.
REQ-009 The block SHALL have port i_valid, input, 1 bit: the branch execute stage resolved a branch this cycle.
REQ-010 The block SHALL have port o_flush, output, 1 bit: registered one-cycle pulse, high the cycle after an accepted kill.
REQ-011 The block SHALL have port o_count, output, WIDTH_BRM+1 bits: the number of tags in flight.
REQ-012 The block SHALL have port o_empty, output, 1 bit: high when count == 0.

Function
REQ-013 Head and tail pointers SHALL each be WIDTH_BRM+1 bits; count = tail - head, computed modulo 2^(WIDTH_BRM+1).
REQ-014 On a grant, tail SHALL increment by 1 at the next edge and the granted tag SHALL be o_tag.
REQ-015 Resolved tag R SHALL equal i_brmask[WIDTH_BRM-1:0] - 1, modulo DEPTH.
REQ-016 When i_valid=1 and R is in flight (head <= R < tail, circular), the block SHALL set resolved[R] at the next edge.
REQ-017 When i_valid=1 and R is not in flight, the block SHALL ignore the resolution entirely, including any kill.
REQ-018 A kill is accepted when i_valid=1, i_brmask[WIDTH_BRM]=1 and R is in flight.
REQ-019 On an accepted kill, the block SHALL take these actions at the next edge:
- set tail to R+1, keeping the extra wrap bit consistent with head;
- clear resolved[] for every tag from R+1 to old tail-1;
- set resolved[R];
- pulse o_flush.
REQ-020 A kill SHALL take priority over a same-cycle allocation; o_gnt is forced low, so the tag is not consumed.
REQ-021 Retirement: each cycle in which count > 0 and resolved[head] = 1, the block SHALL clear resolved[head] and increment head by 1; at most one tag retires per cycle.
REQ-022 A tag resolved in cycle t SHALL retire no earlier than cycle t+1.
REQ-023 In a single cycle, retirement SHALL update head and a grant or kill SHALL update tail, with count reflecting both.
REQ-024 With count == DEPTH, o_ready SHALL be 0; a same-cycle retirement SHALL raise o_ready only in the following cycle.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, and tags SHALL be reused only after they retire.

Reset
REQ-026 While i_rst_n = 0, asynchronously: head = tail = 0, resolved[] = 0, o_flush = 0; hence o_count = 0, o_empty = 1, o_ready = 1, o_tag = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight tags and any pending flush pulse.
REQ-028 After reset releases, the first grant SHALL return tag 0.

Configuration
REQ-029 Macro BRMASK_ALLOC_KILLVEC_EN SHALL control the kill vector port:
- Defined: an extra output o_killvec [DEPTH-1:0] is present. It is registered, one bit set per tag in R+1..old tail-1 squashed by the kill, and valid only while o_flush = 1; otherwise it is 0. Its reset value is 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-030 The bench SHALL cover the following scenarios, with WIDTH_BRM = 4:
- Reset, then i_alloc = 1 for 16 cycles: tags 0..15 granted; o_count = 16, o_ready = 0; 17th request gets o_gnt = 0.
- Allocate 3 tags, then resolve tag 1 (i_brmask = 5'b00010, i_valid = 1), then tag 0: head retires 0 then 1 on consecutive cycles; o_count goes 3 -> 2 -> 1.
- Allocate 5 tags, then kill on tag 1 (i_brmask = 5'b10010): next cycle o_flush = 1 and o_tag = 2; tags 0-1 retire once tag 0 resolves; o_count reaches 0.
- Kill and i_alloc in the same cycle: o_gnt = 0, tail = R+1, no tag lost.
- Wrap: allocate and retire 20 tags one at a time: tags 0..15,0..3 in sequence, with o_empty = 1 between them.
- With BRMASK_ALLOC_KILLVEC_EN defined, allocate 6 tags and kill tag 2: o_killvec = 16'h0038 during the o_flush cycle.
